// File: rtl/clk_switch_pkg.sv
// -----------------------------------------------------------------------------
// clk_switch_pkg
// Shared definitions for the clock-switch controller:
//   - state_e         : 3-bit encoded controller state (also driven on the
//                       debug "state" port, so the encoding is fixed)
//   - DEF_*           : default parameter values for the controller
//   - LOSS_CNT_MAX    : saturation value of the lock-loss counter
//   - sat_inc8()      : saturating increment for 8-bit event counters
// -----------------------------------------------------------------------------
package clk_switch_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_HOLDOFF   = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned DEF_RST_CYCLES      = 32'd16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 32'd65535;
  localparam int unsigned DEF_MAX_RETRY       = 32'd3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 32'd64;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  // Saturating +1: an event counter must stick at its maximum, never wrap.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == LOSS_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clk_switch_debounce.sv
// -----------------------------------------------------------------------------
// clk_switch_debounce
// Brings the raw clock-select switch into the clk domain and debounces it.
// The synchronized request is accepted into sel_stable only after it has
// disagreed with sel_stable for DEBOUNCE_CYCLES consecutive cycles; any
// cycle of agreement restarts the count.
//
// Ports:
//   clk        in   board clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sel_req    in   raw asynchronous select request
//   sel_stable out  debounced select value (registered)
// -----------------------------------------------------------------------------
module clk_switch_debounce
  import clk_switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_req,
  output logic sel_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          stable_q, stable_d;

  // Synchronizer shift and debounce counter next-state.
  always_comb begin
    sync1_d  = sel_req;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
        stable_d = sync2_q;
        cnt_d    = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // State registers for synchronizer, counter and accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sel_stable = stable_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
// Supervises a PLL and a glitch-free clock mux. After reset the PLL is held
// in reset, then the controller waits for LOCKED (retrying a bounded number
// of times before latching FAULT). While running, a debounced select request
// toggles the mux and is followed by a quiet hold-off period. Loss of lock
// while running restarts the PLL and is counted.
//
// Ports:
//   clk           in   free-running board clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sel_req       in   raw asynchronous clock-select request
//   pll_locked    in   asynchronous PLL LOCKED flag
//   pll_rst       out  PLL reset, active high
//   mux_sel       out  mux select (0 = I0, 1 = I1)
//   clk_ok        out  high in RUN / HOLDOFF
//   busy          out  high in every state except RUN
//   fault         out  high in FAULT
//   state         out  encoded controller state (debug)
//   lock_loss_cnt out  saturating lock-loss count
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       mux_sel,
  output logic       clk_ok,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 32'd1);
  localparam int unsigned LCW = $clog2(LOCK_TIMEOUT + 32'd1);
  localparam int unsigned HCW = $clog2(HOLDOFF_CYCLES + 32'd1);
  localparam int unsigned TCW = $clog2(MAX_RETRY + 32'd1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 32'd1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 32'd1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF_CYCLES - 32'd1);
  localparam logic [TCW-1:0] RETRY_MAX = TCW'(MAX_RETRY);

  logic sel_stable_s;

  logic           lock_s1_q,  lock_s1_d;
  logic           lock_s2_q,  lock_s2_d;
  state_e         state_q,    state_d;
  logic [RCW-1:0] rst_cnt_q,  rst_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TCW-1:0] retry_q,    retry_d;
  logic [TCW-1:0] retry_inc_s;
  logic           mux_sel_q,  mux_sel_d;
  logic [7:0]     loss_cnt_q, loss_cnt_d;
  logic           pll_rst_q,  pll_rst_d;
  logic           clk_ok_q,   clk_ok_d;
  logic           busy_q,     busy_d;
  logic           fault_q,    fault_d;

  clk_switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_req   (sel_req),
    .sel_stable(sel_stable_s)
  );

  // Next-state logic: lock synchronizer, FSM transitions, counters, and
  // output values derived from the next state so the flops line up with it.
  always_comb begin
    lock_s1_d   = pll_locked;
    lock_s2_d   = lock_s1_q;
    state_d     = state_q;
    // Per-state timers default to 0, so every state entry starts them fresh.
    rst_cnt_d   = {RCW{1'b0}};
    lock_cnt_d  = {LCW{1'b0}};
    hold_cnt_d  = {HCW{1'b0}};
    retry_d     = retry_q;
    retry_inc_s = retry_q + TCW'(1);
    mux_sel_d   = mux_sel_q;
    loss_cnt_d  = loss_cnt_q;

    case (state_q)
      ST_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s2_q) begin
          state_d = ST_RUN;
          retry_d = {TCW{1'b0}};
        end else if (lock_cnt_q == LOCK_LAST) begin
          retry_d = retry_inc_s;
          if (retry_inc_s == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PLL_RST;
          end
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end

      ST_RUN: begin
        // Lock loss wins over a switch request arriving in the same cycle.
        if (!lock_s2_q) begin
          state_d    = ST_PLL_RST;
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (sel_stable_s != mux_sel_q) begin
          state_d   = ST_HOLDOFF;
          mux_sel_d = ~mux_sel_q;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_HOLDOFF: begin
        // Select changes here are deliberately ignored; RUN re-evaluates them.
        if (!lock_s2_q) begin
          state_d    = ST_PLL_RST;
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    clk_ok_d  = (state_d == ST_RUN) || (state_d == ST_HOLDOFF);
    busy_d    = (state_d != ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      state_q    <= ST_PLL_RST;
      rst_cnt_q  <= {RCW{1'b0}};
      lock_cnt_q <= {LCW{1'b0}};
      hold_cnt_q <= {HCW{1'b0}};
      retry_q    <= {TCW{1'b0}};
      mux_sel_q  <= 1'b0;
      loss_cnt_q <= 8'd0;
      pll_rst_q  <= 1'b1;
      clk_ok_q   <= 1'b0;
      busy_q     <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      lock_s1_q  <= lock_s1_d;
      lock_s2_q  <= lock_s2_d;
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      retry_q    <= retry_d;
      mux_sel_q  <= mux_sel_d;
      loss_cnt_q <= loss_cnt_d;
      pll_rst_q  <= pll_rst_d;
      clk_ok_q   <= clk_ok_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign mux_sel       = mux_sel_q;
  assign clk_ok        = clk_ok_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_switch_ctrl
// Self-checking bench for clk_switch_ctrl. A behavioural model (delay lines
// for the synchronizers, a run-length for the debouncer, and a countdown of
// remaining cycles per state) predicts the controller; scenario tasks also
// check fixed values taken directly from the required behaviour.
// -----------------------------------------------------------------------------
module tb_clk_switch_ctrl;

  localparam int RST_C  = 4;
  localparam int LOCK_T = 20;
  localparam int MAXR   = 3;
  localparam int DEB    = 5;
  localparam int HOLD   = 8;

  logic       clk;
  logic       rst_n;
  logic       sel_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       mux_sel;
  logic       clk_ok;
  logic       busy;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  int m_state, m_left, m_retry, m_mux, m_loss, m_stable, m_run;
  bit lp0, lp1, sp0, sp1;

  clk_switch_ctrl #(
    .RST_CYCLES     (RST_C),
    .LOCK_TIMEOUT   (LOCK_T),
    .MAX_RETRY      (MAXR),
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_req      (sel_req),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .mux_sel      (mux_sel),
    .clk_ok       (clk_ok),
    .busy         (busy),
    .fault        (fault),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_left = RST_C; m_retry = 0; m_mux = 0; m_loss = 0;
    m_stable = 0; m_run = 0; lp0 = 0; lp1 = 0; sp0 = 0; sp1 = 0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_step(input bit lk_in, input bit sel_in);
    bit lk, sv;
    lk = lp1;
    sv = sp1;
    case (m_state)
      0: begin
        m_left--;
        if (m_left == 0) begin m_state = 1; m_left = LOCK_T; end
      end
      1: begin
        if (lk) begin
          m_state = 2; m_retry = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_retry++;
            if (m_retry == MAXR) m_state = 4;
            else begin m_state = 0; m_left = RST_C; end
          end
        end
      end
      2: begin
        if (!lk) begin
          m_state = 0; m_left = RST_C; m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end else if (m_stable != m_mux) begin
          m_mux = 1 - m_mux; m_state = 3; m_left = HOLD;
        end
      end
      3: begin
        if (!lk) begin
          m_state = 0; m_left = RST_C; m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end else begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
      end
      default: ;
    endcase
    if (int'(sv) != m_stable) begin
      m_run++;
      if (m_run == DEB) begin m_stable = int'(sv); m_run = 0; end
    end else begin
      m_run = 0;
    end
    lp1 = lp0; lp0 = lk_in;
    sp1 = sp0; sp0 = sel_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(pll_locked, sel_req);
    #1;
  endtask

  // Assert reset over an edge and release it one time unit after an edge.
  task automatic hold_reset_and_release(input bit lock_val);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    pll_locked = lock_val;
    sel_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; sel_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    total++; if (mux_sel !== 1'b0) begin bad++; $display("FAIL reset_mux_sel got=%b want=0", mux_sel); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL reset_clk_ok got=%b want=0", clk_ok); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL reset_loss got=%0d want=0", lock_loss_cnt); end
  endtask

  task automatic test_bringup();
    int rst_hi;
    rst_hi = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (pll_rst === 1'b1) rst_hi++;
    for (int n = 1; n <= 20; n++) begin
      if (n == 11) pll_locked = 1'b1;
      tick();
      if (pll_rst === 1'b1) rst_hi++;
      total++;
      if (state !== 3'(m_state)) begin bad++; $display("FAIL bringup_state n=%0d got=%0d want=%0d", n, state, m_state); end
      if (n == 13) begin
        total++;
        if (clk_ok !== 1'b1) begin bad++; $display("FAIL bringup_clk_ok_by_13 got=%b want=1", clk_ok); end
      end
    end
    total++; if (rst_hi != RST_C) begin bad++; $display("FAIL bringup_pll_rst_len got=%0d want=%0d", rst_hi, RST_C); end
    total++; if (mux_sel !== 1'b0) begin bad++; $display("FAIL bringup_mux_sel got=%b want=0", mux_sel); end
  endtask

  task automatic test_switch();
    int sw_at, busy_n;
    // short glitch must be filtered
    sel_req = 1'b1;
    repeat (3) tick();
    sel_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (mux_sel !== 1'b0 || state !== 3'd2) begin
        bad++; $display("FAIL glitch_filtered got mux=%b state=%0d want mux=0 state=2", mux_sel, state);
      end
    end
    sel_req = 1'b1;
    sw_at = -1; busy_n = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (sw_at < 0 && mux_sel === 1'b1) sw_at = n;
      if (busy === 1'b1) busy_n++;
      total++;
      if (state !== 3'(m_state) || mux_sel !== m_mux[0]) begin
        bad++; $display("FAIL switch_model n=%0d got st=%0d mux=%b want st=%0d mux=%0d", n, state, mux_sel, m_state, m_mux);
      end
    end
    total++; if (sw_at != 2 + DEB + 1) begin bad++; $display("FAIL switch_latency got=%0d want=%0d", sw_at, 2 + DEB + 1); end
    total++; if (busy_n != HOLD) begin bad++; $display("FAIL switch_busy_len got=%0d want=%0d", busy_n, HOLD); end
    total++; if (mux_sel !== 1'b1) begin bad++; $display("FAIL switch_final_mux got=%b want=1", mux_sel); end
  endtask

  task automatic test_lock_loss();
    sel_req = 1'b0;
    repeat (2 + DEB + 1) tick();
    total++;
    if (mux_sel !== 1'b0 || state !== 3'd3) begin
      bad++; $display("FAIL loss_setup got mux=%b st=%0d want mux=0 st=3", mux_sel, state);
    end
    // pending switch plus lock drop while still in HOLDOFF
    sel_req = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL loss_state got=%0d want=0", state); end
    total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_count got=%0d want=1", lock_loss_cnt); end
    total++; if (mux_sel !== 1'b0) begin bad++; $display("FAIL loss_mux_held got=%b want=0", mux_sel); end
    pll_locked = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      total++;
      if (state !== 3'(m_state) || mux_sel !== m_mux[0]) begin
        bad++; $display("FAIL loss_recover n=%0d got st=%0d mux=%b want st=%0d mux=%0d", n, state, mux_sel, m_state, m_mux);
      end
    end
    total++;
    if (state !== 3'd2 || mux_sel !== 1'b1) begin
      bad++; $display("FAIL loss_pending_switch got st=%0d mux=%b want st=2 mux=1", state, mux_sel);
    end
  endtask

  task automatic test_timeout();
    int waits;
    logic [2:0] prev;
    hold_reset_and_release(1'b0);
    waits = 0;
    prev = state;
    for (int n = 1; n <= MAXR * (RST_C + LOCK_T); n++) begin
      tick();
      if (prev == 3'd0 && state == 3'd1) waits++;
      prev = state;
      total++;
      if (state !== 3'(m_state)) begin bad++; $display("FAIL timeout_state n=%0d got=%0d want=%0d", n, state, m_state); end
    end
    total++; if (waits != MAXR) begin bad++; $display("FAIL timeout_attempts got=%0d want=%0d", waits, MAXR); end
    total++;
    if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b1 || busy !== 1'b1 || clk_ok !== 1'b0) begin
      bad++; $display("FAIL timeout_fault got st=%0d f=%b pr=%b b=%b ok=%b want 4 1 1 1 0", state, fault, pll_rst, busy, clk_ok);
    end
    pll_locked = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (n % 7 == 0) sel_req = ~sel_req;
      tick();
      total++;
      if (fault !== 1'b1 || pll_rst !== 1'b1) begin bad++; $display("FAIL fault_terminal n=%0d got f=%b pr=%b want 1 1", n, fault, pll_rst); end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL fault_rst_recover got f=%b st=%0d want 0 0", fault, state); end
  endtask

  task automatic test_saturation();
    int exp_loss;
    hold_reset_and_release(1'b1);
    repeat (20) tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL sat_bringup got=%0d want=2", state); end
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      repeat (12) tick();
      exp_loss = (i + 1 > 255) ? 255 : i + 1;
      total++;
      if (lock_loss_cnt !== exp_loss[7:0] || state !== 3'd2) begin
        bad++; $display("FAIL sat_count i=%0d got cnt=%0d st=%0d want cnt=%0d st=2", i, lock_loss_cnt, state, exp_loss);
      end
    end
    total++; if (lock_loss_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", lock_loss_cnt); end
  endtask

  task automatic test_reset_mid();
    int rst_hi;
    for (int sc = 0; sc < 2; sc++) begin
      if (sc == 0) begin
        pll_locked = 1'b0;
        repeat (3 + RST_C + 2) tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL mid_setup_wait got=%0d want=1", state); end
      end else begin
        pll_locked = 1'b1;
        repeat (20) tick();
        sel_req = ~mux_sel;
        repeat (2 + DEB + 1 + 2) tick();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mid_setup_holdoff got=%0d want=3", state); end
      end
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (state !== 3'd0 || pll_rst !== 1'b1 || mux_sel !== 1'b0 || clk_ok !== 1'b0 ||
          busy !== 1'b1 || fault !== 1'b0 || lock_loss_cnt !== 8'd0) begin
        bad++; $display("FAIL mid_reset_async sc=%0d got st=%0d pr=%b mux=%b ok=%b b=%b f=%b cnt=%0d", sc, state, pll_rst, mux_sel, clk_ok, busy, fault, lock_loss_cnt);
      end
      @(posedge clk);
      #1;
      sel_req = 1'b0;
      pll_locked = 1'b1;
      rst_n = 1'b1;
      rst_hi = (pll_rst === 1'b1) ? 1 : 0;
      for (int n = 0; n < 8; n++) begin
        tick();
        if (pll_rst === 1'b1) rst_hi++;
      end
      total++; if (rst_hi != RST_C) begin bad++; $display("FAIL mid_fresh_pulse sc=%0d got=%0d want=%0d", sc, rst_hi, RST_C); end
    end
  endtask

  task automatic test_random();
    int low_left;
    logic [2:0] e_st;
    hold_reset_and_release(1'b1);
    low_left = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) sel_req = ~sel_req;
      if (low_left > 0) begin
        low_left--;
        pll_locked = (low_left == 0);
      end else if ($urandom_range(0, 59) == 0) begin
        low_left = $urandom_range(1, 6);
        pll_locked = 1'b0;
      end
      tick();
      e_st = 3'(m_state);
      total++;
      if (state !== e_st || mux_sel !== m_mux[0] || lock_loss_cnt !== m_loss[7:0] ||
          pll_rst !== (m_state == 0 || m_state == 4) || clk_ok !== (m_state == 2 || m_state == 3) ||
          busy !== (m_state != 2) || fault !== (m_state == 4)) begin
        bad++;
        $display("FAIL random n=%0d got st=%0d mux=%b cnt=%0d pr=%b ok=%b b=%b f=%b want st=%0d mux=%0d cnt=%0d",
                 n, state, mux_sel, lock_loss_cnt, pll_rst, clk_ok, busy, fault, m_state, m_mux, m_loss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_switch();
    test_lock_loss();
    test_timeout();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
